// File: rtl/vga_v_sync.sv
// Vertical line counter and sync/blanking generator for 640x480@60 VGA.
// Consumes the upstream horizontal count and its end-of-line pulse, and
// registers the vertical count, hsync/vsync, video_on, visible pixel
// coordinates and a start-of-frame pulse, all aligned to the same pixel.
//
// Ports:
//   i_clk          pixel clock
//   i_rst_n        synchronous active-low reset
//   i_h_count      horizontal position from the upstream counter
//   i_trig_v       upstream end-of-line pulse (coincident with h_count==0)
//   o_v_count      current line, 0..V_TOTAL-1
//   o_hsync        registered horizontal sync
//   o_vsync        registered vertical sync
//   o_video_on     high while the pixel is in the visible area
//   o_pixel_x      visible column, 0 when blanked
//   o_pixel_y      visible row, 0 when blanked
//   o_frame_start  one-cycle pulse marking pixel (0,0)
module vga_v_sync #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter logic        SYNC_POL  = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [9:0] i_h_count,
   input  logic       i_trig_v,
   output logic [9:0] o_v_count,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_video_on,
   output logic [9:0] o_pixel_x,
   output logic [9:0] o_pixel_y,
   output logic       o_frame_start
);

   localparam int unsigned CW = 10;

   localparam logic [CW-1:0] C_H_VIS   = CW'(H_VISIBLE);
   localparam logic [CW-1:0] C_HS_BEG  = CW'(H_VISIBLE + H_FP);
   localparam logic [CW-1:0] C_HS_END  = CW'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [CW-1:0] C_H_TOT   = CW'(H_VISIBLE + H_FP + H_SYNC + H_BP);
   localparam logic [CW-1:0] C_V_VIS   = CW'(V_VISIBLE);
   localparam logic [CW-1:0] C_VS_BEG  = CW'(V_VISIBLE + V_FP);
   localparam logic [CW-1:0] C_VS_END  = CW'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [CW-1:0] C_V_LAST  = CW'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

   logic          r_trig_d;
   logic [CW-1:0] r_v_count;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_video_on;
   logic [CW-1:0] r_pixel_x;
   logic [CW-1:0] r_pixel_y;
   logic          r_frame_start;

   logic          w_advance;
   logic [CW-1:0] w_line;
   logic          w_hsync_act;
   logic          w_vsync_act;
   logic          w_video;

   // Effective line for this cycle and region decode on (h_count, line)
   always_comb begin
      w_advance   = i_trig_v & ~r_trig_d;
      w_line      = r_v_count;
      if (w_advance) begin
         w_line = (r_v_count == C_V_LAST) ? '0 : r_v_count + CW'(1);
      end
      // Out-of-range h_count falls outside both windows and is plain blanking
      w_hsync_act = (i_h_count >= C_HS_BEG) && (i_h_count < C_HS_END) &&
                    (i_h_count < C_H_TOT);
      w_vsync_act = (w_line >= C_VS_BEG) && (w_line < C_VS_END);
      w_video     = (i_h_count < C_H_VIS) && (w_line < C_V_VIS);
   end

   // Output registers; every output describes the same (h_count, line) pixel
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_trig_d      <= 1'b0;
         r_v_count     <= '0;
         r_hsync       <= ~SYNC_POL;
         r_vsync       <= ~SYNC_POL;
         r_video_on    <= 1'b0;
         r_pixel_x     <= '0;
         r_pixel_y     <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_trig_d      <= i_trig_v;
         r_v_count     <= w_line;
         r_hsync       <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
         r_vsync       <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
         r_video_on    <= w_video;
         r_pixel_x     <= w_video ? i_h_count : '0;
         r_pixel_y     <= w_video ? w_line : '0;
         r_frame_start <= w_advance && (w_line == '0);
      end
   end

   assign o_v_count     = r_v_count;
   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_video_on    = r_video_on;
   assign o_pixel_x     = r_pixel_x;
   assign o_pixel_y     = r_pixel_y;
   assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_v_sync.sv
// Self-checking bench for vga_v_sync: hand-computed vector table, directed
// corner sequences and random stimulus against a frame-level reference model.
module tb_vga_v_sync;

   localparam int V_TOTAL = 525;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] h_count = '0;
   logic       trig_v = 1'b0;
   logic [9:0] v_count;
   logic       hsync, vsync, video_on, frame_start;
   logic [9:0] pixel_x, pixel_y;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model state: current line and previous trig_v
   int mline = 0;
   bit mtd   = 1'b0;

   vga_v_sync dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_h_count     (h_count),
      .i_trig_v      (trig_v),
      .o_v_count     (v_count),
      .o_hsync       (hsync),
      .o_vsync       (vsync),
      .o_video_on    (video_on),
      .o_pixel_x     (pixel_x),
      .o_pixel_y     (pixel_y),
      .o_frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic check10(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then compare every output with the model
   task automatic step(input logic rst, input int h, input logic trg);
      int  l;
      bit  adv;
      bit  e_hs, e_vs, e_vo, e_fs;
      int  e_px, e_py;
      rst_n   = rst;
      h_count = 10'(h);
      trig_v  = trg;
      if (!rst) begin
         l = 0; e_hs = 1; e_vs = 1; e_vo = 0; e_px = 0; e_py = 0; e_fs = 0;
      end else begin
         adv  = trg && !mtd;
         l    = adv ? (mline + 1) % V_TOTAL : mline;
         e_hs = !(h >= 656 && h < 752);
         e_vs = !(l >= 490 && l < 492);
         e_vo = (h < 640) && (l < 480);
         e_px = e_vo ? h : 0;
         e_py = e_vo ? l : 0;
         e_fs = adv && (l == 0);
      end
      @(posedge clk);
      #1;
      cyc++;
      check10("model_v_count", v_count, 10'(l));
      check1 ("model_hsync", hsync, e_hs);
      check1 ("model_vsync", vsync, e_vs);
      check1 ("model_video_on", video_on, e_vo);
      check10("model_pixel_x", pixel_x, 10'(e_px));
      check10("model_pixel_y", pixel_y, 10'(e_py));
      check1 ("model_frame_start", frame_start, e_fs);
      mline = l;
      mtd   = rst ? trg : 1'b0;
   endtask

   // Advance quickly to a given line using short two-cycle lines
   task automatic goto_line(input int target);
      int guard = 0;
      while (mline != target && guard < 1200) begin
         step(1'b1, 0, 1'b1);
         step(1'b1, 1, 1'b0);
         guard++;
      end
      n_checks++;
      if (mline != target) begin
         n_fail++;
         $display("FAIL goto_line timeout: at line %0d, wanted %0d", mline, target);
      end
   endtask

   typedef struct {
      logic       rst;
      int         h;
      logic       trg;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       vo;
      logic [9:0] px;
      logic [9:0] py;
      logic       fs;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int vs_low;
      int fs_cyc;
      int period;
      int start_line;
      int guard;

      //           rst   h    trg  v      hs    vs    vo    px      py     fs
      tbl[0]  = '{1'b0, 0,   1'b1, 10'd0, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
      tbl[1]  = '{1'b0, 5,   1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
      tbl[2]  = '{1'b1, 10,  1'b0, 10'd0, 1'b1, 1'b1, 1'b1, 10'd10,  10'd0, 1'b0};
      tbl[3]  = '{1'b1, 0,   1'b1, 10'd1, 1'b1, 1'b1, 1'b1, 10'd0,   10'd1, 1'b0};
      tbl[4]  = '{1'b1, 0,   1'b1, 10'd1, 1'b1, 1'b1, 1'b1, 10'd0,   10'd1, 1'b0};
      tbl[5]  = '{1'b1, 656, 1'b0, 10'd1, 1'b0, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
      tbl[6]  = '{1'b1, 751, 1'b0, 10'd1, 1'b0, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
      tbl[7]  = '{1'b1, 752, 1'b0, 10'd1, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
      tbl[8]  = '{1'b1, 639, 1'b0, 10'd1, 1'b1, 1'b1, 1'b1, 10'd639, 10'd1, 1'b0};
      tbl[9]  = '{1'b1, 640, 1'b0, 10'd1, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
      tbl[10] = '{1'b1, 900, 1'b0, 10'd1, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
      tbl[11] = '{1'b0, 400, 1'b1, 10'd0, 1'b1, 1'b1, 1'b0, 10'd0,   10'd0, 1'b0};
      tbl[12] = '{1'b1, 0,   1'b1, 10'd1, 1'b1, 1'b1, 1'b1, 10'd0,   10'd1, 1'b0};

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].rst, tbl[i].h, tbl[i].trg);
         check10("tbl_v_count", v_count, tbl[i].v);
         check1 ("tbl_hsync", hsync, tbl[i].hs);
         check1 ("tbl_vsync", vsync, tbl[i].vs);
         check1 ("tbl_video_on", video_on, tbl[i].vo);
         check10("tbl_pixel_x", pixel_x, tbl[i].px);
         check10("tbl_pixel_y", pixel_y, tbl[i].py);
         check1 ("tbl_frame_start", frame_start, tbl[i].fs);
      end

      // hsync window on line 10
      goto_line(10);
      for (int h = 650; h <= 760; h++) begin
         step(1'b1, h, 1'b0);
         if (h == 655) check1("hs_655", hsync, 1'b1);
         if (h == 656) check1("hs_656", hsync, 1'b0);
         if (h == 751) check1("hs_751", hsync, 1'b0);
         if (h == 752) check1("hs_752", hsync, 1'b1);
      end

      // Last visible pixel and first blanked column of line 479
      goto_line(479);
      step(1'b1, 639, 1'b0);
      check1 ("last_px_vo", video_on, 1'b1);
      check10("last_px_x", pixel_x, 10'd639);
      check10("last_px_y", pixel_y, 10'd479);
      step(1'b1, 640, 1'b0);
      check1 ("blank_vo", video_on, 1'b0);
      check10("blank_x", pixel_x, 10'd0);

      // Full-length lines 488..494: vsync low for exactly two lines
      goto_line(487);
      vs_low = 0;
      for (int ln = 0; ln < 7; ln++) begin
         for (int h = 0; h < 800; h++) begin
            step(1'b1, h, h == 0);
            if (vsync == 1'b0) vs_low++;
         end
      end
      n_checks++;
      if (vs_low != 1600) begin
         n_fail++;
         $display("FAIL vsync_low_cycles: got %0d, expected 1600", vs_low);
      end

      // Wrap from line 524 gives frame_start with pixel (0,0)
      goto_line(524);
      step(1'b1, 0, 1'b1);
      check10("wrap_v_count", v_count, 10'd0);
      check1 ("wrap_fs", frame_start, 1'b1);
      check1 ("wrap_vo", video_on, 1'b1);
      check10("wrap_px", pixel_x, 10'd0);
      check10("wrap_py", pixel_y, 10'd0);
      fs_cyc = cyc;
      step(1'b1, 1, 1'b0);
      check1 ("wrap_fs_single", frame_start, 1'b0);

      // Next frame_start exactly 525 lines later (two-cycle lines here)
      period = -1;
      guard  = 0;
      while (period < 0 && guard < 1500) begin
         step(1'b1, 0, 1'b1);
         if (frame_start) period = cyc - fs_cyc;
         else begin
            step(1'b1, 1, 1'b0);
         end
         guard++;
      end
      n_checks++;
      if (period != 2 * V_TOTAL) begin
         n_fail++;
         $display("FAIL frame_period: got %0d cycles, expected %0d", period, 2 * V_TOTAL);
      end

      // Stuck-high trig_v advances exactly one line; h_count out of range
      step(1'b1, 5, 1'b0);
      start_line = mline;
      step(1'b1, 0, 1'b1);
      step(1'b1, 0, 1'b1);
      step(1'b1, 0, 1'b1);
      step(1'b1, 900, 1'b0);
      check10("stuck_v_count", v_count, 10'(start_line + 1));
      check1 ("h900_hsync", hsync, 1'b1);
      check1 ("h900_video_on", video_on, 1'b0);

      // Mid-frame reset
      goto_line(300);
      step(1'b1, 400, 1'b0);
      step(1'b0, 400, 1'b0);
      check10("midrst_v_count", v_count, 10'd0);
      check1 ("midrst_vsync", vsync, 1'b1);
      check1 ("midrst_video_on", video_on, 1'b0);
      check1 ("midrst_fs", frame_start, 1'b0);
      step(1'b1, 0, 1'b1);
      check10("midrst_next_line", v_count, 10'd1);

      // Random stimulus against the model
      for (int k = 0; k < 4000; k++) begin
         step(($urandom % 200) != 0, int'($urandom % 1024), ($urandom % 3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_v_sync.md
# vga_v_sync

Vertical line counter and sync/blanking generator for the 640x480@60 VGA path. It sits directly downstream of the horizontal pixel counter and consumes that counter's `h_count` and its one-cycle end-of-line pulse `trig_v`. It produces the vertical count, registered `hsync`/`vsync`, `video_on`, visible-pixel coordinates and a start-of-frame pulse for the pixel generator. Everything runs on the pixel clock.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal porch and sync widths. Line total H_TOTAL = 800, which must match the upstream counter wrap.
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical porch and sync widths. V_TOTAL = 525.
- `SYNC_POL`, 0, sync active level (0 = active-low, as VGA 640x480 requires)
- `clk` in 1: pixel clock, the only clock
- `rst_n` in 1: reset, synchronous, active-low
- `h_count` in 10: horizontal position 0..H_TOTAL-1 from the upstream counter
- `trig_v` in 1: upstream end-of-line pulse, high for one cycle coincident with `h_count`==0
- `v_count` out 10: current line, 0..V_TOTAL-1
- `hsync` out 1: registered horizontal sync
- `vsync` out 1: registered vertical sync
- `video_on` out 1: high while the pixel is in the visible area
- `pixel_x` out 10: visible column, 0 when blanked
- `pixel_y` out 10: visible row, 0 when blanked
- `frame_start` out 1: one-cycle pulse marking pixel (0,0)

## Operation
- Internal `trig_d` holds `trig_v` delayed by one cycle. A line advance occurs only on `trig_v` & ~`trig_d`, so a stuck-high `trig_v` advances exactly one line.
- Effective line L for the current input cycle:
  - On an advance: L = (`v_count` == V_TOTAL-1) ? 0 : `v_count`+1.
  - Otherwise: L = `v_count`.
- Every clock edge when `rst_n`=1 registers all of the following:
  - `v_count` <= L
  - `hsync` <= SYNC_POL when H_VISIBLE+H_FP <= `h_count` < H_VISIBLE+H_FP+H_SYNC (656..751); else ~SYNC_POL
  - `vsync` <= SYNC_POL when V_VISIBLE+V_FP <= L < V_VISIBLE+V_FP+V_SYNC (490..491); else ~SYNC_POL
  - `video_on` <= (`h_count` < H_VISIBLE) & (L < V_VISIBLE)
  - `pixel_x` <= `video_on`-condition ? `h_count` : 0
  - `pixel_y` <= `video_on`-condition ? L : 0
  - `frame_start` <= advance & (L == 0)
- Any `h_count` >= H_TOTAL is treated as horizontal blanking: `hsync` inactive, `video_on`=0. No error is flagged.
- All comparisons are unsigned at 10 bits. `v_count` never exceeds V_TOTAL-1.
- There is no FSM beyond the line counter. Region decode is purely a comparison on `h_count` and L.

## Timing
- Reset (`rst_n`=0 sampled at a rising edge) sets:
  - `v_count`=0, `trig_d`=0
  - `hsync`=`vsync`=~SYNC_POL (1 by default)
  - `video_on`=0, `pixel_x`=`pixel_y`=0, `frame_start`=0
- Reset has priority over an advance in the same cycle.
- Reset mid-line or mid-frame:
  - Restarts at line 0, with no `frame_start` emitted.
  - The next `trig_v` rising edge moves to line 1.
  - The first `frame_start` follows the first wrap from line 524.
- Latency: outputs at cycle t+1 describe the pixel at (`h_count`(t), L(t)). All outputs share this alignment, so `v_count` and `hsync` never skew.
- `v_count` changes on the edge that samples `trig_v` and is visible together with the outputs for `h_count`=0.
- Frame period = 800 x 525 = 420000 cycles between `frame_start` pulses.
- `frame_start` and `v_count`=0 appear in the same cycle. `video_on` is high in that cycle and `pixel_x`=`pixel_y`=0.

## Test plan
- Reset hold, then release with the upstream counter free-running:
  - During reset, all outputs hold their reset values.
  - The first `trig_v` gives `v_count`=1 on the following cycle.
- Full frame from line 524:
  - `trig_v` at `v_count`=524 gives `v_count`=0 and a single-cycle `frame_start`=1 on the next cycle.
  - The next `frame_start` arrives exactly 420000 cycles later.
- hsync window, checked on line 10:
  - `h_count`=655 gives `hsync`=1 next cycle.
  - `h_count`=656..751 gives `hsync`=0.
  - `h_count`=752 gives `hsync`=1.
- vsync and visibility:
  - `vsync`=0 for exactly lines 490..491 (1600 cycles).
  - `video_on`=1 exactly for `h_count`<640 on lines <480.
  - (639,479) gives `pixel_x`=639, `pixel_y`=479, `video_on`=1.
  - (640,479) gives `video_on`=0 and `pixel_x`=0.
- Robustness: hold `trig_v` high for 3 cycles, then drive `h_count`=900.
  - `v_count` advances by exactly 1.
  - For `h_count`=900: `hsync`=1 and `video_on`=0.
- Mid-frame reset at line 300, `h_count`=400: next outputs are `v_count`=0, `vsync`=1, `video_on`=0, `frame_start`=0.
